obi_arbiter: RTL and testbench
==============================

OBI_ARBITER -- requirements
Module: obi_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of OBI manager ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8; BE_WIDTH = DATA_WIDTH/8).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, maximum number of granted transactions still awaiting rvalid (1..8).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk_i, input, 1, clock; all state rising-edge.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports m_req_i, m_we_i, input, NUM_PORTS each, per-manager request and write enable.
REQ-009 SHALL have ports m_addr_i (NUM_PORTS*ADDR_WIDTH), m_be_i (NUM_PORTS*BE_WIDTH) and m_wdata_i (NUM_PORTS*DATA_WIDTH), all inputs, packed per manager with port 0 in the LSBs.
REQ-010 SHALL have ports m_gnt_o and m_rvalid_o, output, NUM_PORTS each, per-manager grant and response valid.
REQ-011 SHALL have port m_rdata_o, output, DATA_WIDTH, read data broadcast to all managers.
REQ-012 SHALL have ports s_req_o, s_we_o (1), s_addr_o (ADDR_WIDTH), s_be_o (BE_WIDTH) and s_wdata_o (DATA_WIDTH), all outputs, subordinate address phase.
REQ-013 SHALL have ports s_gnt_i, s_rvalid_i (1) and s_rdata_i (DATA_WIDTH), all inputs, subordinate grant and response.
REQ-014 SHALL have port err_o, output, 1, sticky error flag: rvalid received with no outstanding transaction.

Function
REQ-015 SHALL select one requesting manager per cycle by round-robin: the lowest index at or above priority pointer ptr, wrapping at NUM_PORTS.
REQ-016 SHALL combinationally drive s_addr_o, s_we_o, s_be_o and s_wdata_o from the selected manager.
REQ-017 SHALL assert s_req_o = (any m_req_i) AND (outstanding count < MAX_OUTSTANDING).
REQ-018 SHALL assert m_gnt_o[sel] = s_req_o AND s_gnt_i, and hold all other m_gnt_o bits at 0.
REQ-019 SHALL latch sel into a lock register whenever s_req_o=1 and s_gnt_i=0, and keep sel fixed while locked, so the subordinate sees a stable address phase until grant.
REQ-020 SHALL clear the lock and set ptr to (sel+1) mod NUM_PORTS on each handshake (s_req_o and s_gnt_i).
REQ-021 SHALL push sel into an ID FIFO of depth MAX_OUTSTANDING on each handshake, with 0-cycle issue latency.
REQ-022 SHALL, on s_rvalid_i, pop the FIFO head, assert m_rvalid_o[head] in the same cycle (combinational), and pass s_rdata_i to m_rdata_o.
REQ-023 SHALL track outstanding count as count + push - pop each cycle; a simultaneous push and pop leaves count unchanged and is legal at any fill level.
REQ-024 SHALL ignore a new request when the FIFO is full even if s_rvalid_i is high in the same cycle (s_req_o depends on registered count only).
REQ-025 SHALL, on s_rvalid_i with count=0, drive all m_rvalid_o to 0, leave the FIFO unchanged and set err_o until reset.
REQ-026 SHALL wrap FIFO read and write pointers modulo MAX_OUTSTANDING.
REQ-027 SHALL not drop the lock while s_req_o is deasserted by the full condition; the locked index is retained.

Reset
REQ-028 SHALL, on rst_ni=0, clear ptr, lock, count, FIFO pointers and err_o immediately, regardless of clk_i.
REQ-029 SHALL, while in reset, drive s_req_o=0, m_gnt_o=0 and m_rvalid_o=0; data outputs are don't-care.
REQ-030 SHALL discard all outstanding transactions on reset mid-operation; responses arriving after reset release set err_o.

Verification
REQ-031 SHALL cover: m_req_i=2'b11 held, s_gnt_i=1, s_rvalid_i one cycle later -> grants alternate 0,1,0,1, and rvalid returns to matching ports in order.
REQ-032 SHALL cover: port 1 requests with s_gnt_i=0 for 3 cycles, port 0 raises req in cycle 2 -> s_addr_o stays port 1's address until grant, then port 0 is granted next.
REQ-033 SHALL cover: MAX_OUTSTANDING=2, two grants with no rvalid -> s_req_o=0 and third request stalls; one rvalid -> s_req_o=1 the next cycle.
REQ-034 SHALL cover: count=2 with rvalid and request in the same cycle -> no grant that cycle, count becomes 1, grant the following cycle.
REQ-035 SHALL cover: s_rvalid_i=1 with count=0 -> m_rvalid_o=0 and err_o=1 held until rst_ni=0.
REQ-036 SHALL cover: rst_ni pulsed low with 2 outstanding -> count=0, ptr=0, outputs low, and a fresh request from port 0 is granted first.

Source files
------------

// File: rtl/obi_arbiter.sv
// Round-robin arbiter that merges several OBI managers onto one subordinate port.
// Response routing uses an in-order ID FIFO, which bounds how many transactions can be outstanding.
module obi_arbiter #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_PORTS-1:0]             m_req_i,
  input  logic [NUM_PORTS-1:0]             m_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    m_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  m_wdata_i,
  output logic [NUM_PORTS-1:0]             m_gnt_o,
  output logic [NUM_PORTS-1:0]             m_rvalid_o,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic                             s_req_o,
  output logic                             s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [BE_WIDTH-1:0]              s_be_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic                             s_gnt_i,
  input  logic                             s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            s_rdata_i,
  output logic                             err_o
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            locked_q, locked_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];

  logic [IdxW-1:0] sel_rr, sel, head, rr_cand;
  logic            rr_found;
  logic            handshake, pop;

  // Lowest requesting index at or above ptr, wrapping at NUM_PORTS.
  always_comb begin
    sel_rr   = ptr_q;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      rr_cand = IdxW'((32'(ptr_q) + k) % NUM_PORTS);
      if (!rr_found && m_req_i[rr_cand]) begin
        rr_found = 1'b1;
        sel_rr   = rr_cand;
      end
    end
  end

  assign sel       = locked_q ? lock_idx_q : sel_rr;
  assign s_req_o   = rst_ni & (|m_req_i) & (count_q < CntW'(MAX_OUTSTANDING));
  assign handshake = s_req_o & s_gnt_i;
  assign pop       = rst_ni & s_rvalid_i & (count_q != '0);
  assign head      = fifo_q[rptr_q];

  assign s_we_o    = m_we_i[sel];
  assign s_addr_o  = m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_be_o    = m_be_i[sel*BE_WIDTH +: BE_WIDTH];
  assign s_wdata_o = m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign m_rdata_o = s_rdata_i;
  assign err_o     = err_q;

  always_comb begin
    m_gnt_o          = '0;
    m_gnt_o[sel]     = handshake;
    m_rvalid_o       = '0;
    m_rvalid_o[head] = pop;
  end

  always_comb begin
    ptr_d      = ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (handshake) begin
      locked_d = 1'b0;
      ptr_d    = (sel == IdxW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
    end else if (s_req_o) begin
      // Freeze the address phase until the subordinate grants it.
      locked_d   = 1'b1;
      lock_idx_d = sel;
    end
  end

  always_comb begin
    count_d = count_q + CntW'(handshake) - CntW'(pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (handshake) begin
      wptr_d = (wptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
    end
    err_d = err_q | (s_rvalid_i & (count_q == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: only entries between rptr and wptr are ever read.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      fifo_q[wptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_obi_arbiter.sv
// Bench for obi_arbiter: directed rows with literal expectations, then random traffic,
// with every cycle compared against a queue-based reference model.
module tb_obi_arbiter;

  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    m_req_i, m_we_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*BW-1:0] m_be_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N-1:0]    m_gnt_o, m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_req_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [BW-1:0]   s_be_o;
  logic [DW-1:0]   s_wdata_o;
  logic            s_gnt_i, s_rvalid_i;
  logic [DW-1:0]   s_rdata_i;
  logic            err_o;

  obi_arbiter #(
    .NUM_PORTS      (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .m_req_i   (m_req_i),
    .m_we_i    (m_we_i),
    .m_addr_i  (m_addr_i),
    .m_be_i    (m_be_i),
    .m_wdata_i (m_wdata_i),
    .m_gnt_o   (m_gnt_o),
    .m_rvalid_o(m_rvalid_o),
    .m_rdata_o (m_rdata_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_be_o    (s_be_o),
    .s_wdata_o (s_wdata_o),
    .s_gnt_i   (s_gnt_i),
    .s_rvalid_i(s_rvalid_i),
    .s_rdata_i (s_rdata_i),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rotation pointer, held selection, queue of issued port ids, sticky error.
  int     mptr = 0;
  bit     mlock = 0;
  int     mlock_idx = 0;
  int     mq[$];
  bit     merr = 0;
  int     msel;
  bit     m_sreq, m_hs, m_pop;
  logic [N-1:0] m_egnt, m_erv;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("rst_sreq", s_req_o, 0);
      check("rst_gnt", m_gnt_o, 0);
      check("rst_rvalid", m_rvalid_o, 0);
      check("rst_err", err_o, 0);
      mptr = 0; mlock = 0; mlock_idx = 0; merr = 0;
      mq.delete();
    end else begin
      m_sreq = (m_req_i != 0) && (mq.size() < MAXO);
      msel = -1;
      if (mlock) msel = mlock_idx;
      else begin
        for (int k = 0; k < N; k++)
          if (msel < 0 && m_req_i[(mptr + k) % N]) msel = (mptr + k) % N;
      end
      m_hs  = m_sreq && s_gnt_i;
      m_pop = s_rvalid_i && (mq.size() > 0);
      m_egnt = '0;
      if (m_hs) m_egnt[msel] = 1'b1;
      m_erv = '0;
      if (m_pop) m_erv[mq[0]] = 1'b1;

      check("sreq", s_req_o, m_sreq);
      check("gnt", m_gnt_o, m_egnt);
      check("rvalid", m_rvalid_o, m_erv);
      check("err", err_o, merr);
      if (m_sreq) begin
        check("addr", s_addr_o, m_addr_i[msel*AW +: AW]);
        check("we", s_we_o, m_we_i[msel]);
        check("be", s_be_o, m_be_i[msel*BW +: BW]);
        check("wdata", s_wdata_o, m_wdata_i[msel*DW +: DW]);
      end
      if (m_pop) check("rdata", m_rdata_o, s_rdata_i);

      if (s_rvalid_i && mq.size() == 0) merr = 1;
      if (m_pop) void'(mq.pop_front());
      if (m_hs) begin
        mq.push_back(msel);
        mlock = 0;
        mptr = (msel + 1) % N;
      end else if (m_sreq) begin
        mlock = 1;
        mlock_idx = msel;
      end
    end
  end

  int row_n = 0;

  task automatic row(input bit rst, input logic [N-1:0] req, input bit g, input bit rv,
                     input bit e_sreq, input logic [N-1:0] e_gnt, input logic [N-1:0] e_rv,
                     input bit e_err, input int ap);
    rst_ni = rst; m_req_i = req; s_gnt_i = g; s_rvalid_i = rv;
    s_rdata_i = 32'hD000_0000 + 32'(row_n);
    @(negedge clk_i);
    check($sformatf("row%0d_sreq", row_n), s_req_o, e_sreq);
    check($sformatf("row%0d_gnt", row_n), m_gnt_o, e_gnt);
    check($sformatf("row%0d_rvalid", row_n), m_rvalid_o, e_rv);
    check($sformatf("row%0d_err", row_n), err_o, e_err);
    if (ap >= 0) check($sformatf("row%0d_addr", row_n), s_addr_o, 32'h4000_0000 + 32'(ap * 256));
    row_n++;
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_ni = 1'b0; m_req_i = '0; m_we_i = 3'b101; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    s_rdata_i = '0;
    m_be_i = 12'hF3C;
    m_wdata_i = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    m_addr_i  = {32'h4000_0200, 32'h4000_0100, 32'h4000_0000};
    @(posedge clk_i); #1;
    //   rst req    g  rv  sreq gnt     rv_o    err addr
    row(0, 3'b001, 1, 1,  0,  3'b000, 3'b000, 0, -1);  // requests ignored in reset
    row(0, 3'b001, 1, 0,  0,  3'b000, 3'b000, 0, -1);
    row(1, 3'b011, 1, 0,  1,  3'b001, 3'b000, 0,  0);  // alternating grants
    row(1, 3'b011, 1, 1,  1,  3'b010, 3'b001, 0,  1);
    row(1, 3'b011, 1, 1,  1,  3'b001, 3'b010, 0,  0);
    row(1, 3'b011, 1, 1,  1,  3'b010, 3'b001, 0,  1);
    row(1, 3'b000, 1, 1,  0,  3'b000, 3'b010, 0, -1);
    row(1, 3'b010, 0, 0,  1,  3'b000, 3'b000, 0,  1);  // port 1 held without grant
    row(1, 3'b011, 0, 0,  1,  3'b000, 3'b000, 0,  1);
    row(1, 3'b011, 0, 0,  1,  3'b000, 3'b000, 0,  1);
    row(1, 3'b011, 1, 0,  1,  3'b010, 3'b000, 0,  1);
    row(1, 3'b001, 1, 0,  1,  3'b001, 3'b000, 0,  0);
    row(1, 3'b011, 1, 0,  0,  3'b000, 3'b000, 0, -1);  // full: stall
    row(1, 3'b011, 1, 1,  0,  3'b000, 3'b010, 0, -1);  // rvalid while full: still no grant
    row(1, 3'b011, 1, 0,  1,  3'b010, 3'b000, 0,  1);
    row(1, 3'b000, 0, 1,  0,  3'b000, 3'b001, 0, -1);
    row(1, 3'b000, 0, 1,  0,  3'b000, 3'b010, 0, -1);
    row(1, 3'b000, 0, 1,  0,  3'b000, 3'b000, 0, -1);  // stray rvalid
    row(1, 3'b000, 0, 0,  0,  3'b000, 3'b000, 1, -1);
    row(1, 3'b011, 1, 0,  1,  3'b001, 3'b000, 1,  0);
    row(1, 3'b011, 1, 0,  1,  3'b010, 3'b000, 1,  1);
    row(1, 3'b011, 1, 0,  0,  3'b000, 3'b000, 1, -1);
    row(0, 3'b011, 1, 0,  0,  3'b000, 3'b000, 0, -1);  // reset with 2 outstanding
    row(1, 3'b111, 1, 1,  1,  3'b001, 3'b000, 0,  0);  // ptr back to 0; stale rvalid
    row(1, 3'b000, 0, 0,  0,  3'b000, 3'b000, 1, -1);
    row(1, 3'b000, 0, 1,  0,  3'b000, 3'b001, 1, -1);

    for (int c = 0; c < 3000; c++) begin
      rst_ni    = ($urandom_range(0, 299) != 0);
      m_req_i   = 3'($urandom_range(0, 7));
      m_we_i    = 3'($urandom_range(0, 7));
      m_addr_i  = {$urandom, $urandom, $urandom};
      m_be_i    = 12'($urandom_range(0, 4095));
      m_wdata_i = {$urandom, $urandom, $urandom};
      s_rdata_i = $urandom;
      s_gnt_i   = ($urandom_range(0, 9) < 7);
      if (mq.size() > 0) s_rvalid_i = ($urandom_range(0, 1) == 1);
      else               s_rvalid_i = ($urandom_range(0, 99) == 0);
      @(posedge clk_i); #1;
    end

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
